// File: rtl/conv_pkg.sv
`default_nettype none
// ---------------------------------------------------------------
// conv_pkg : shared types and size helpers for conv2 and its drain
// rev 1.0
// ---------------------------------------------------------------
package conv_pkg;

  localparam int SAMPLE_W = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FIN    = 2'd2
  } state_e;

  function automatic int calc_outsz(input int size, input int size_ker);
    return size - size_ker + 1;
  endfunction

  // Index width never collapses to zero, even for a 1x1 or 2x2 result.
  function automatic int calc_idxw(input int outsz);
    return (outsz <= 2) ? 1 : $clog2(outsz);
  endfunction

endpackage
`default_nettype wire

// File: rtl/raster_counter.sv
`default_nettype none
// ---------------------------------------------------------------
// raster_counter : row-major row/col counter with wrap and last flag
// rev 1.0
// ---------------------------------------------------------------
module raster_counter #(
  parameter int OUTSZ = 4,
  parameter int IDXW  = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            clear,
  input  logic            en,
  output logic [IDXW-1:0] row,
  output logic [IDXW-1:0] col,
  output logic [IDXW-1:0] next_row,
  output logic [IDXW-1:0] next_col,
  output logic            last
);

  localparam logic [IDXW-1:0] MAX_IDX = IDXW'(OUTSZ - 1);

  logic [IDXW-1:0] r_row;
  logic [IDXW-1:0] r_col;

  always_comb begin
    next_row = r_row;
    next_col = r_col + 1'b1;
    if (r_col == MAX_IDX) begin
      next_col = '0;
      next_row = (r_row == MAX_IDX) ? '0 : r_row + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_row <= '0;
      r_col <= '0;
    end else if (en) begin
      r_row <= next_row;
      r_col <= next_col;
    end
  end

  assign row  = r_row;
  assign col  = r_col;
  assign last = (r_row == MAX_IDX) && (r_col == MAX_IDX);

endmodule
`default_nettype wire

// File: rtl/conv_out_streamer.sv
`default_nettype none
// ---------------------------------------------------------------
// conv_out_streamer : drains the conv2 result matrix as a raster stream
// rev 1.0
// ---------------------------------------------------------------
module conv_out_streamer
  import conv_pkg::*;
#(
  parameter int SIZE      = 256,
  parameter int SIZEKer   = 3,
  parameter int WIDTH_BIT = 16,
  localparam int OUTSZ    = calc_outsz(SIZE, SIZEKer),
  localparam int IDXW     = calc_idxw(OUTSZ)
) (
  input  logic                                        clock,
  input  logic                                        reset,
  input  logic                                        done,
  input  logic signed [OUTSZ-1:0][OUTSZ-1:0][WIDTH_BIT-1:0] convIxKernelOut,
  input  logic                                        m_ready,
  output logic                                        m_valid,
  output logic signed [WIDTH_BIT-1:0]                 m_data,
  output logic [IDXW-1:0]                             m_row,
  output logic [IDXW-1:0]                             m_col,
  output logic                                        m_first,
  output logic                                        m_last,
  output logic                                        busy,
  output logic                                        frame_done
);

  state_e          r_state;
  state_e          w_next_state;
  logic            r_done_q;
  logic            w_start;
  logic            w_load_first;
  logic            w_xfer;
  logic            w_last;
  logic [IDXW-1:0] w_next_row;
  logic [IDXW-1:0] w_next_col;

  assign w_start      = done & ~r_done_q;
  assign w_load_first = w_start && (r_state == IDLE);
  assign w_xfer       = m_valid & m_ready;

  raster_counter #(
    .OUTSZ (OUTSZ),
    .IDXW  (IDXW)
  ) u_raster (
    .clock    (clock),
    .reset    (reset),
    .clear    (w_load_first),
    .en       (w_xfer),
    .row      (m_row),
    .col      (m_col),
    .next_row (w_next_row),
    .next_col (w_next_col),
    .last     (w_last)
  );

  // done_q resets high so a done level already present at release is not an edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= IDLE;
      r_done_q <= 1'b1;
    end else begin
      r_state  <= w_next_state;
      r_done_q <= done;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_start) w_next_state = STREAM;
      STREAM:  if (w_xfer && w_last) w_next_state = FIN;
      FIN:     w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    m_valid    = (r_state == STREAM);
    busy       = (r_state == STREAM);
    frame_done = (r_state == FIN);
    m_first    = m_valid && (m_row == '0) && (m_col == '0);
    m_last     = m_valid && w_last;
  end

  // Next sample is fetched on the accepting edge so back-to-back beats need no bubble.
  always_ff @(posedge clock) begin
    if (reset) begin
      m_data <= '0;
    end else if (w_load_first) begin
      m_data <= convIxKernelOut[0][0];
    end else if (w_xfer && !w_last) begin
      m_data <= convIxKernelOut[w_next_row][w_next_col];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_out_streamer.sv
`default_nettype none
// ---------------------------------------------------------------
// tb_conv_out_streamer : directed bench for conv_out_streamer, 4x4 result
// rev 1.0
// ---------------------------------------------------------------
module tb_conv_out_streamer;

  logic                         clock = 1'b0;
  logic                         reset;
  logic                         done;
  logic [3:0][3:0][15:0]        mat;
  logic                         m_ready;
  logic                         m_valid;
  logic signed [15:0]           m_data;
  logic [1:0]                   m_row;
  logic [1:0]                   m_col;
  logic                         m_first;
  logic                         m_last;
  logic                         busy;
  logic                         frame_done;

  int vectors     = 0;
  int miscompares = 0;
  logic [15:0] cap [16];

  conv_out_streamer #(
    .SIZE      (6),
    .SIZEKer   (3),
    .WIDTH_BIT (16)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .done            (done),
    .convIxKernelOut (mat),
    .m_ready         (m_ready),
    .m_valid         (m_valid),
    .m_data          (m_data),
    .m_row           (m_row),
    .m_col           (m_col),
    .m_first         (m_first),
    .m_last          (m_last),
    .busy            (busy),
    .frame_done      (frame_done)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_beat(input int idx);
    int r;
    int c;
    r = idx / 4;
    c = idx % 4;
    chk($sformatf("valid[%0d]", idx), 16'(m_valid), 16'd1);
    chk($sformatf("busy[%0d]", idx), 16'(busy), 16'd1);
    chk($sformatf("data[%0d]", idx), 16'(m_data), mat[r][c]);
    chk($sformatf("row[%0d]", idx), 16'(m_row), 16'(r));
    chk($sformatf("col[%0d]", idx), 16'(m_col), 16'(c));
    chk($sformatf("first[%0d]", idx), 16'(m_first), 16'(idx == 0));
    chk($sformatf("last[%0d]", idx), 16'(m_last), 16'(idx == 15));
    chk($sformatf("fdone[%0d]", idx), 16'(frame_done), 16'd0);
  endtask

  // Entered the cycle the first beat is presented.
  task automatic run_frame(input int stall_idx, input int stall_len);
    int cyc;
    cyc = 0;
    for (int i = 0; i < 16; i++) begin
      check_beat(i);
      cap[i] = 16'(m_data);
      if (i == stall_idx) begin
        m_ready = 1'b0;
        for (int k = 0; k < stall_len; k++) begin
          step();
          cyc++;
          check_beat(i);
        end
        m_ready = 1'b1;
      end
      step();
      cyc++;
    end
    chk("fin_fdone", 16'(frame_done), 16'd1);
    chk("fin_busy", 16'(busy), 16'd0);
    chk("fin_valid", 16'(m_valid), 16'd0);
    chk("fin_cycles", 16'(cyc), 16'(16 + stall_len));
    step();
    chk("post_fdone", 16'(frame_done), 16'd0);
  endtask

  task automatic start_edge();
    done = 1'b0;
    step();
    done = 1'b1;
    step();
  endtask

  initial begin
    int vcount;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        mat[r][c] = 16'(r * 16 + c);
    reset   = 1'b1;
    done    = 1'b0;
    m_ready = 1'b1;
    step();
    step();

    chk("rst_valid", 16'(m_valid), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_data", 16'(m_data), 16'd0);
    chk("rst_row", 16'(m_row), 16'd0);
    chk("rst_col", 16'(m_col), 16'd0);
    chk("rst_first", 16'(m_first), 16'd0);
    chk("rst_last", 16'(m_last), 16'd0);
    chk("rst_fdone", 16'(frame_done), 16'd0);
    reset = 1'b0;
    step();
    chk("idle_valid", 16'(m_valid), 16'd0);

    // Free-flowing frame.
    start_edge();
    run_frame(-1, 0);

    // Three-cycle stall on beat 6 (row 1, col 1).
    start_edge();
    chk("stall_pre_data", mat[1][1], 16'h0011);
    run_frame(5, 3);

    // done held high: one frame only, then retrigger after a low cycle.
    start_edge();
    run_frame(-1, 0);
    vcount = 0;
    for (int i = 0; i < 22; i++) begin
      step();
      if (m_valid) vcount++;
    end
    chk("held_done_retrig", 16'(vcount), 16'd0);
    start_edge();
    run_frame(-1, 0);

    // Reset while beat 7 is presented.
    start_edge();
    for (int i = 0; i < 6; i++) step();
    chk("b7_row", 16'(m_row), 16'd1);
    chk("b7_col", 16'(m_col), 16'd2);
    chk("b7_data", 16'(m_data), 16'h0012);
    reset = 1'b1;
    step();
    chk("midrst_valid", 16'(m_valid), 16'd0);
    chk("midrst_busy", 16'(busy), 16'd0);
    chk("midrst_data", 16'(m_data), 16'd0);
    chk("midrst_row", 16'(m_row), 16'd0);
    reset = 1'b0;
    start_edge();
    chk("restart_data", 16'(m_data), 16'h0000);
    run_frame(-1, 0);

    // Negative and most-negative samples pass through unchanged.
    mat[2][3] = 16'hFFFF;
    mat[3][0] = 16'h8000;
    start_edge();
    run_frame(-1, 0);
    chk("beat12_neg1", cap[11], 16'hFFFF);
    chk("beat13_min", cap[12], 16'h8000);

    // done high across reset release must not start a frame.
    reset = 1'b1;
    done  = 1'b1;
    step();
    step();
    reset = 1'b0;
    vcount = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (m_valid) vcount++;
    end
    chk("done_at_release", 16'(vcount), 16'd0);
    start_edge();
    run_frame(-1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
